// File: rtl/m_ext_ctrl_pkg.sv
// Shared encodings for the RV32M execute-stage sequencer: funct3 codes, FSM states
// and the fixed results returned by the divide special-case fast path.
package m_ext_ctrl_pkg;

   localparam int DEF_XLEN    = 32;
   localparam int DEF_LATENCY = 4;
   localparam int DEF_RD_W    = 5;

   typedef enum logic [2:0] {
      F3_MUL    = 3'b000,
      F3_MULH   = 3'b001,
      F3_MULHSU = 3'b010,
      F3_MULHU  = 3'b011,
      F3_DIV    = 3'b100,
      F3_DIVU   = 3'b101,
      F3_REM    = 3'b110,
      F3_REMU   = 3'b111
   } funct3_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_HOLD = 2'd1,
      S_DONE = 2'd2
   } state_e;

   localparam logic [DEF_XLEN-1:0] XLEN_MIN_NEG   = 32'h8000_0000;
   localparam logic [DEF_XLEN-1:0] XLEN_ALL_ONES  = 32'hFFFF_FFFF;
   localparam logic [DEF_XLEN-1:0] DIV_OVF_RESULT = XLEN_MIN_NEG;
   localparam logic [DEF_XLEN-1:0] REM_OVF_RESULT = 32'h0000_0000;

   // funct3[2] separates the divide/remainder group from the multiplies
   function automatic logic is_div_op(input logic [2:0] f3);
      return f3[2];
   endfunction

endpackage

// File: rtl/m_ext_ctrl_if.sv
// Handshake/operand bundle between ID/EX, the sequencer, m_ext and writeback.
// The slave view is the sequencer; the master view is everything around it.
interface m_ext_ctrl_if
   import m_ext_ctrl_pkg::*;
#(
   parameter int XLEN = DEF_XLEN,
   parameter int RD_W = DEF_RD_W
);

   logic            ip_valid;
   logic [XLEN-1:0] ip_rs1;
   logic [XLEN-1:0] ip_rs2;
   logic [2:0]      ip_funct_3;
   logic [RD_W-1:0] ip_rd;
   logic            ip_flush;
   logic            ip_wb_ready;
   logic [XLEN-1:0] ip_m_result;
   logic            ip_m_overflow;

   logic            op_ready;
   logic            op_stall;
   logic [XLEN-1:0] op_m_rs1;
   logic [XLEN-1:0] op_m_rs2;
   logic [2:0]      op_m_funct_3;
   logic            op_wb_valid;
   logic [XLEN-1:0] op_wb_result;
   logic [RD_W-1:0] op_wb_rd;
   logic            op_wb_overflow;

   modport slave (
      input  ip_valid, ip_rs1, ip_rs2, ip_funct_3, ip_rd, ip_flush, ip_wb_ready,
             ip_m_result, ip_m_overflow,
      output op_ready, op_stall, op_m_rs1, op_m_rs2, op_m_funct_3,
             op_wb_valid, op_wb_result, op_wb_rd, op_wb_overflow
   );

   modport master (
      output ip_valid, ip_rs1, ip_rs2, ip_funct_3, ip_rd, ip_flush, ip_wb_ready,
             ip_m_result, ip_m_overflow,
      input  op_ready, op_stall, op_m_rs1, op_m_rs2, op_m_funct_3,
             op_wb_valid, op_wb_result, op_wb_rd, op_wb_overflow
   );

endinterface

// File: rtl/m_ext_special.sv
// Combinational detect of divide-by-zero and signed-overflow divides, with the
// architecturally defined result so these ops can skip the m_ext unit.
module m_ext_special
   import m_ext_ctrl_pkg::*;
#(
   parameter int XLEN = DEF_XLEN
) (
   input  logic [XLEN-1:0] rs1_i,
   input  logic [XLEN-1:0] rs2_i,
   input  logic [2:0]      funct_3_i,
   output logic            hit_o,
   output logic [XLEN-1:0] result_o,
   output logic            overflow_o
);

   logic div_zero;
   logic signed_ovf;

   always_comb begin
      div_zero   = is_div_op(funct_3_i) && (rs2_i == '0);
      signed_ovf = ((funct_3_i == F3_DIV) || (funct_3_i == F3_REM)) &&
                   (rs1_i == XLEN_MIN_NEG) && (rs2_i == XLEN_ALL_ONES);

      // funct3[1] selects the remainder flavour in both special cases
      result_o = '0;
      if (div_zero) begin
         result_o = funct_3_i[1] ? rs1_i : XLEN_ALL_ONES;
      end else if (signed_ovf) begin
         result_o = funct_3_i[1] ? REM_OVF_RESULT : DIV_OVF_RESULT;
      end

      hit_o      = div_zero || signed_ovf;
      overflow_o = hit_o;
   end

endmodule

// File: rtl/m_ext_ctrl.sv
// Execute-stage sequencer for m_ext: latches one M-op, holds operands for LATENCY
// cycles, captures the result and hands it to writeback; divide special cases finish in one cycle.
module m_ext_ctrl
   import m_ext_ctrl_pkg::*;
#(
   parameter int XLEN    = DEF_XLEN,
   parameter int LATENCY = DEF_LATENCY,
   parameter int RD_W    = DEF_RD_W
) (
   input  logic        ip_clk,
   input  logic        ip_rst,
   m_ext_ctrl_if.slave bus
);

   localparam int               CNT_W    = $clog2(LATENCY) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

   state_e          state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [XLEN-1:0] rs1_q, rs1_d;
   logic [XLEN-1:0] rs2_q, rs2_d;
   logic [2:0]      f3_q, f3_d;
   logic [RD_W-1:0] rd_q, rd_d;
   logic [XLEN-1:0] res_q, res_d;
   logic            ovf_q, ovf_d;

   logic            accept;
   logic            spec_hit;
   logic [XLEN-1:0] spec_res;
   logic            spec_ovf;

   assign accept = (state_q == S_IDLE) && bus.ip_valid && !bus.ip_flush;

   m_ext_special #(.XLEN(XLEN)) u_special (
      .rs1_i      (bus.ip_rs1),
      .rs2_i      (bus.ip_rs2),
      .funct_3_i  (bus.ip_funct_3),
      .hit_o      (spec_hit),
      .result_o   (spec_res),
      .overflow_o (spec_ovf)
   );

   always_ff @(posedge ip_clk) begin
      if (ip_rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Operand/result storage carries no reset: outputs are gated by state instead
   always_ff @(posedge ip_clk) begin
      rs1_q <= rs1_d;
      rs2_q <= rs2_d;
      f3_q  <= f3_d;
      rd_q  <= rd_d;
      res_q <= res_d;
      ovf_q <= ovf_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d = spec_hit ? S_DONE : S_HOLD;
            end
         end
         S_HOLD: begin
            if (bus.ip_flush) begin
               state_d = S_IDLE;
            end else if (cnt_q == CNT_LAST) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (bus.ip_flush || bus.ip_wb_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      cnt_d = cnt_q;
      rs1_d = rs1_q;
      rs2_d = rs2_q;
      f3_d  = f3_q;
      rd_d  = rd_q;
      res_d = res_q;
      ovf_d = ovf_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               rs1_d = bus.ip_rs1;
               rs2_d = bus.ip_rs2;
               f3_d  = bus.ip_funct_3;
               rd_d  = bus.ip_rd;
               cnt_d = '0;
               if (spec_hit) begin
                  res_d = spec_res;
                  ovf_d = spec_ovf;
               end
            end
         end
         S_HOLD: begin
            // Counter saturates at the capture point; it is only cleared on the next accept
            if (!bus.ip_flush) begin
               if (cnt_q == CNT_LAST) begin
                  res_d = bus.ip_m_result;
                  ovf_d = bus.ip_m_overflow;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      bus.op_ready       = 1'b0;
      bus.op_stall       = 1'b0;
      bus.op_m_rs1       = '0;
      bus.op_m_rs2       = '0;
      bus.op_m_funct_3   = '0;
      bus.op_wb_valid    = 1'b0;
      bus.op_wb_result   = '0;
      bus.op_wb_rd       = '0;
      bus.op_wb_overflow = 1'b0;
      case (state_q)
         S_IDLE: begin
            bus.op_ready = 1'b1;
         end
         S_HOLD: begin
            bus.op_stall     = 1'b1;
            bus.op_m_rs1     = rs1_q;
            bus.op_m_rs2     = rs2_q;
            bus.op_m_funct_3 = f3_q;
         end
         S_DONE: begin
            bus.op_stall       = 1'b1;
            bus.op_m_rs1       = rs1_q;
            bus.op_m_rs2       = rs2_q;
            bus.op_m_funct_3   = f3_q;
            bus.op_wb_valid    = 1'b1;
            bus.op_wb_result   = res_q;
            bus.op_wb_rd       = rd_q;
            bus.op_wb_overflow = ovf_q;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_m_ext_ctrl.sv
// Bench for m_ext_ctrl: a latency-checking m_ext model plus a writeback scoreboard.
module tb_m_ext_ctrl;
   import m_ext_ctrl_pkg::*;

   localparam int XLEN = 32;
   localparam int LAT  = 4;
   localparam int RD_W = 5;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   m_ext_ctrl_if #(.XLEN(XLEN), .RD_W(RD_W)) bus ();

   m_ext_ctrl #(.XLEN(XLEN), .LATENCY(LAT), .RD_W(RD_W)) dut (
      .ip_clk (clk),
      .ip_rst (rst),
      .bus    (bus)
   );

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [31:0] res;
      logic [4:0]  rd;
      logic        ovf;
      int          lat;
   } exp_t;

   exp_t exp_q[$];
   exp_t e_mon;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference RV32M arithmetic; overflow flag models a MUL whose product leaves 32 bits
   function automatic logic [32:0] mref(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] ps;
      logic [63:0]        pu;
      logic signed [65:0] psu;
      logic [31:0]        r;
      logic               o;
      ps  = $signed(a) * $signed(b);
      pu  = {32'b0, a} * {32'b0, b};
      psu = $signed({{34{a[31]}}, a}) * $signed({34'b0, b});
      o   = 1'b0;
      r   = '0;
      case (f3)
         3'b000: begin r = ps[31:0]; o = (ps != {{32{ps[31]}}, ps[31:0]}); end
         3'b001: r = ps[63:32];
         3'b010: r = psu[63:32];
         3'b011: r = pu[63:32];
         3'b100: if (b == 0) r = '1; else if (a == 32'h8000_0000 && b == '1) r = a; else r = $signed(a) / $signed(b);
         3'b101: if (b == 0) r = '1; else r = a / b;
         3'b110: if (b == 0) r = a; else if (a == 32'h8000_0000 && b == '1) r = '0; else r = $signed(a) % $signed(b);
         default: if (b == 0) r = a; else r = a % b;
      endcase
      return {o, r};
   endfunction

   function automatic exp_t expect_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
      exp_t        e;
      logic [32:0] m;
      e.rd = rd;
      if (f3[2] && b == 0) begin
         e.res = f3[1] ? a : 32'hFFFF_FFFF;
         e.ovf = 1'b1;
         e.lat = 1;
      end else if ((f3 == 3'b100 || f3 == 3'b110) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         e.res = f3[1] ? 32'h0 : 32'h8000_0000;
         e.ovf = 1'b1;
         e.lat = 1;
      end else begin
         m     = mref(f3, a, b);
         e.res = m[31:0];
         e.ovf = m[32];
         e.lat = LAT + 1;
      end
      return e;
   endfunction

   // m_ext model: result is only valid once operands have been stable for LAT cycles
   logic [31:0] pm_rs1 = '0;
   logic [31:0] pm_rs2 = '0;
   logic [2:0]  pm_f3  = '0;
   int          run_q  = 0;
   int          run_now;
   logic [32:0] mres;

   always_comb begin
      run_now = (bus.op_m_rs1 === pm_rs1 && bus.op_m_rs2 === pm_rs2 && bus.op_m_funct_3 === pm_f3) ? run_q + 1 : 1;
      mres    = mref(bus.op_m_funct_3, bus.op_m_rs1, bus.op_m_rs2);
   end

   always @(posedge clk) begin
      pm_rs1 <= bus.op_m_rs1;
      pm_rs2 <= bus.op_m_rs2;
      pm_f3  <= bus.op_m_funct_3;
      run_q  <= (run_now > 1000) ? 1000 : run_now;
   end

   assign bus.ip_m_result   = (run_now >= LAT) ? mres[31:0] : 32'hDEAD_BEEF;
   assign bus.ip_m_overflow = (run_now >= LAT) ? mres[32] : 1'b1;

   always @(negedge clk) begin
      if (!rst && bus.op_wb_valid === 1'b1 && bus.ip_wb_ready && !bus.ip_flush) begin
         if (exp_q.size() == 0) begin
            chk("sb_unexpected", 1, 0);
         end else begin
            e_mon = exp_q.pop_front();
            chk("wb_result", bus.op_wb_result, e_mon.res);
            chk("wb_rd", bus.op_wb_rd, e_mon.rd);
            chk("wb_ovf", bus.op_wb_overflow, e_mon.ovf);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3, input logic [4:0] rd);
      bus.ip_valid   = 1'b1;
      bus.ip_rs1     = a;
      bus.ip_rs2     = b;
      bus.ip_funct_3 = f3;
      bus.ip_rd      = rd;
      @(negedge clk);
      chk("accept_ready", bus.op_ready, 1);
      step();
      bus.ip_valid = 1'b0;
   endtask

   // Returns at the negedge of the first op_wb_valid cycle
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3, input logic [4:0] rd);
      exp_t e;
      int   n;
      int   bad_ctl;
      int   bad_m;
      e = expect_op(f3, a, b, rd);
      exp_q.push_back(e);
      send(a, b, f3, rd);
      n       = 0;
      bad_ctl = 0;
      bad_m   = 0;
      do begin
         @(negedge clk);
         n++;
         if (bus.op_wb_valid !== 1'b1) begin
            if (bus.op_stall !== 1'b1 || bus.op_ready !== 1'b0) bad_ctl++;
            if (bus.op_m_rs1 !== a || bus.op_m_rs2 !== b || bus.op_m_funct_3 !== f3) bad_m++;
         end
      end while (bus.op_wb_valid !== 1'b1 && n < 40);
      chk("wb_latency", n, e.lat);
      chk("hold_ctrl", bad_ctl, 0);
      chk("hold_operands", bad_m, 0);
      chk("done_stall", bus.op_stall, 1);
      chk("done_ready", bus.op_ready, 0);
   endtask

   task automatic idle_outputs(input string tag);
      chk({tag, "_ready"}, bus.op_ready, 1);
      chk({tag, "_stall"}, bus.op_stall, 0);
      chk({tag, "_wbv"}, bus.op_wb_valid, 0);
      chk({tag, "_res"}, bus.op_wb_result, 0);
      chk({tag, "_rd"}, bus.op_wb_rd, 0);
      chk({tag, "_ovf"}, bus.op_wb_overflow, 0);
      chk({tag, "_mrs1"}, bus.op_m_rs1, 0);
      chk({tag, "_mrs2"}, bus.op_m_rs2, 0);
      chk({tag, "_mf3"}, bus.op_m_funct_3, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout got=running exp=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      int   seen;
      logic [31:0] a;
      logic [31:0] b;
      logic [2:0]  f3;

      bus.ip_valid    = 1'b0;
      bus.ip_rs1      = '0;
      bus.ip_rs2      = '0;
      bus.ip_funct_3  = '0;
      bus.ip_rd       = '0;
      bus.ip_flush    = 1'b0;
      bus.ip_wb_ready = 1'b1;

      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      idle_outputs("reset");
      step();
      rst = 1'b0;

      run_op(32'd89211, 32'd1418, F3_MUL, 5'd5);
      step();

      run_op(32'h003A_E27C, 32'h0, F3_DIV, 5'd6);
      step();
      run_op(32'h003A_E27C, 32'h0, F3_DIVU, 5'd7);
      step();
      run_op(32'h1234_5678, 32'h0, F3_REM, 5'd8);
      step();
      run_op(32'h8765_4321, 32'h0, F3_REMU, 5'd9);
      step();

      run_op(32'h8000_0000, 32'hFFFF_FFFF, F3_DIV, 5'd10);
      step();
      run_op(32'h8000_0000, 32'hFFFF_FFFF, F3_REM, 5'd11);
      step();
      run_op(32'h8000_0000, 32'hFFFF_FFFF, F3_DIVU, 5'd12);
      step();

      // Writeback back-pressure in DONE
      bus.ip_wb_ready = 1'b0;
      e = expect_op(F3_MULH, 32'h7654_3210, 32'hFFFF_FF9D, 5'd13);
      run_op(32'h7654_3210, 32'hFFFF_FF9D, F3_MULH, 5'd13);
      repeat (3) begin
         @(posedge clk);
         @(negedge clk);
         chk("bp_valid", bus.op_wb_valid, 1);
         chk("bp_result", bus.op_wb_result, e.res);
         chk("bp_rd", bus.op_wb_rd, e.rd);
         chk("bp_stall", bus.op_stall, 1);
      end
      step();
      bus.ip_wb_ready = 1'b1;
      step();
      @(negedge clk);
      chk("bp_release_ready", bus.op_ready, 1);
      step();

      // Flush alongside ip_valid in IDLE: nothing accepted
      bus.ip_valid   = 1'b1;
      bus.ip_flush   = 1'b1;
      bus.ip_rs1     = 32'd5;
      bus.ip_rs2     = 32'd7;
      bus.ip_funct_3 = F3_MUL;
      step();
      bus.ip_valid = 1'b0;
      bus.ip_flush = 1'b0;
      @(negedge clk);
      chk("idle_flush_ready", bus.op_ready, 1);
      chk("idle_flush_stall", bus.op_stall, 0);
      step();

      // Flush in the second HOLD cycle
      send(32'd1000, 32'd3000, F3_MUL, 5'd14);
      step();
      bus.ip_flush = 1'b1;
      @(negedge clk);
      chk("hold_flush_stall", bus.op_stall, 1);
      step();
      bus.ip_flush = 1'b0;
      @(negedge clk);
      chk("hold_flush_ready", bus.op_ready, 1);
      seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (bus.op_wb_valid !== 1'b0) seen++;
      end
      chk("hold_flush_no_wb", seen, 0);
      step();
      run_op(32'd1000003, 32'd97, F3_REMU, 5'd15);
      step();

      // Flush wins over ip_wb_ready in DONE
      send(32'd42, 32'd0, F3_DIV, 5'd16);
      bus.ip_flush = 1'b1;
      @(negedge clk);
      chk("done_flush_valid", bus.op_wb_valid, 1);
      step();
      bus.ip_flush = 1'b0;
      @(negedge clk);
      chk("done_flush_ready", bus.op_ready, 1);
      chk("done_flush_wbv", bus.op_wb_valid, 0);
      step();

      // Reset during HOLD, with a new ip_valid presented while busy
      send(32'hCAFE_0001, 32'h0000_0123, F3_MULHU, 5'd17);
      bus.ip_valid   = 1'b1;
      bus.ip_rs1     = 32'd9;
      bus.ip_rs2     = 32'd9;
      bus.ip_funct_3 = F3_MUL;
      bus.ip_rd      = 5'd18;
      @(negedge clk);
      chk("busy_ready", bus.op_ready, 0);
      step();
      bus.ip_valid = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      @(negedge clk);
      idle_outputs("midrst");
      seen = 0;
      repeat (8) begin
         @(negedge clk);
         if (bus.op_wb_valid !== 1'b0) seen++;
      end
      chk("midrst_no_wb", seen, 0);
      step();

      for (int i = 0; i < 10; i++) begin
         f3 = 3'($urandom_range(0, 7));
         a  = $urandom;
         b  = $urandom;
         if (i % 4 == 3) b = '0;
         if (i == 5) begin
            a  = 32'h8000_0000;
            b  = 32'hFFFF_FFFF;
            f3 = F3_REM;
         end
         run_op(a, b, f3, 5'(i + 20));
         step();
      end

      chk("sb_drain", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
